// File: rtl/ab_gen_if.sv
// ab_gen_if: sequencer <-> address generator bundle (control in, address buses out).
// Latency: n/a (wires only); AD/page_cross are combinational, AB/PC/busy are registered in ab_gen.
// Backpressure: hold (RDY low) freezes the generator; no other flow control.
// Ports: op/db/idx/ld_opl/ld_pc/inc_pc/hold driven by the sequencer (master),
//        AD/AB/PC/page_cross/busy driven by ab_gen (slave).
interface ab_gen_if #(
   parameter int AW = 16,
   parameter int PW = 8
);
   logic [4:0]    op;
   logic [PW-1:0] db;
   logic [PW-1:0] idx;
   logic          ld_opl;
   logic          ld_pc;
   logic          inc_pc;
   logic          hold;
   logic [AW-1:0] AD;
   logic [AW-1:0] AB;
   logic [AW-1:0] PC;
   logic          page_cross;
   logic          busy;

   modport master (
      output op, db, idx, ld_opl, ld_pc, inc_pc, hold,
      input  AD, AB, PC, page_cross, busy
   );

   modport slave (
      input  op, db, idx, ld_opl, ld_pc, inc_pc, hold,
      output AD, AB, PC, page_cross, busy
   );
endinterface

// File: rtl/ab_gen.sv
// ab_gen: full-width address generator (base + offset) with optional page-cross fix-up cycle.
// Latency: AD combinational, AB/PC one clk; a page cross in FIXUP mode costs one extra cycle (busy=1).
// Backpressure: hold freezes AB, OPL and FSM state (a pending fix-up survives hold); PC still loads.
// Ports: clk, rst (async active-high), bus (ab_gen_if.slave): op[4:3] base, op[2:1] offset,
//        op[0] page-wrap, db, idx, ld_opl, ld_pc, inc_pc, hold in; AD, AB, PC, page_cross, busy out.
module ab_gen #(
   parameter int            AW       = 16,
   parameter int            PW       = 8,
   parameter int            FIXUP    = 0,
   parameter logic [AW-1:0] RESET_AB = AW'(16'hFFFC)
) (
   input  logic    clk,
   input  logic    rst,
   ab_gen_if.slave bus
);

   localparam int HW = AW - PW;   // width of the page (high) part

   typedef enum logic {
      S_IDLE = 1'b0,
      S_FIX  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic          dec_q, dec_d;     // latched fix-up direction: 1 = decrement high part
   logic [PW-1:0] opl_q;
   logic [AW-1:0] ab_q;
   logic [AW-1:0] pc_q;

   logic [AW-1:0] base;
   logic [AW-1:0] offset;
   logic [AW-1:0] full_sum;
   logic [PW:0]   low_sum;
   logic          carry;
   logic          is_dec;
   logic          pcross;
   logic [AW-1:0] ad;
   logic [HW-1:0] ab_hi_adj;

   // Base select
   always_comb begin
      case (bus.op[4:3])
         2'b00:   base = '0;
         2'b01:   base = ab_q;
         2'b10:   base = pc_q;
         default: base = {HW'(bus.db), opl_q};
      endcase
   end

   // Offset select; idx only reaches the adder when selected, so an unknown
   // idx cannot leak into AD for the other offsets.
   always_comb begin
      case (bus.op[2:1])
         2'b00:   offset = '0;
         2'b01:   offset = AW'(1);
         2'b10:   offset = AW'(bus.idx);
         default: offset = '1;
      endcase
   end

   assign is_dec   = (bus.op[2:1] == 2'b11);
   assign low_sum  = {1'b0, base[PW-1:0]} + {1'b0, offset[PW-1:0]};
   assign carry    = low_sum[PW];
   assign full_sum = base + offset;

   // High part of the held address, nudged one page in the latched direction.
   assign ab_hi_adj = dec_q ? (ab_q[AW-1:PW] - HW'(1)) : (ab_q[AW-1:PW] + HW'(1));

   // Next-state / next-address logic
   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      ad      = full_sum;
      pcross  = 1'b0;
      if (state_q == S_FIX) begin
         // op is ignored: finish the deferred carry/borrow on the held address
         ad      = {ab_hi_adj, ab_q[PW-1:0]};
         state_d = S_IDLE;
      end else if (bus.op[0]) begin
         // page wrap: high part passes through untouched
         ad = {base[AW-1:PW], low_sum[PW-1:0]};
      end else begin
         // adding all-ones borrows exactly when there is no carry out
         pcross = is_dec ? ~carry : carry;
         if (FIXUP != 0) begin
            ad = {base[AW-1:PW], low_sum[PW-1:0]};
            if (pcross) begin
               state_d = S_FIX;
               dec_d   = is_dec;
            end
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         dec_q   <= 1'b0;
      end else if (!bus.hold) begin
         state_q <= state_d;
         dec_q   <= dec_d;
      end
   end

   // Address, operand latch and program counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ab_q  <= RESET_AB;
         opl_q <= '0;
         pc_q  <= '0;
      end else begin
         if (!bus.hold) begin
            ab_q <= ad;
            if (bus.ld_opl) begin
               opl_q <= bus.db;
            end
         end
         // PC ignores hold and always uses the pre-edge AB (unfixed during a fix-up)
         if (bus.ld_pc) begin
            pc_q <= ab_q + AW'(bus.inc_pc);
         end
      end
   end

   assign bus.AD         = ad;
   assign bus.AB         = ab_q;
   assign bus.PC         = pc_q;
   assign bus.page_cross = pcross;
   assign bus.busy       = (state_q == S_FIX);

endmodule

// File: tb/tb_ab_gen.sv
// tb_ab_gen: directed bench for ab_gen in four builds (16-bit single-cycle, 16-bit fix-up,
// 24-bit, 12-bit); all builds share clk/rst and see the same control inputs.
// Outputs are sampled 1 time unit after the rising edge or after inputs settle.
module tb_ab_gen;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   ab_gen_if #(.AW(16), .PW(8)) i0 ();
   ab_gen_if #(.AW(16), .PW(8)) i1 ();
   ab_gen_if #(.AW(24), .PW(8)) i24 ();
   ab_gen_if #(.AW(12), .PW(8)) i12 ();

   ab_gen #(.AW(16), .PW(8), .FIXUP(0)) u0   (.clk(clk), .rst(rst), .bus(i0.slave));
   ab_gen #(.AW(16), .PW(8), .FIXUP(1)) u1   (.clk(clk), .rst(rst), .bus(i1.slave));
   ab_gen #(.AW(24), .PW(8), .FIXUP(0)) u24  (.clk(clk), .rst(rst), .bus(i24.slave));
   ab_gen #(.AW(12), .PW(8), .FIXUP(0)) u12  (.clk(clk), .rst(rst), .bus(i12.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [4:0] v);
      i0.op = v; i1.op = v; i24.op = v; i12.op = v;
   endtask

   task automatic set_db(input logic [7:0] v);
      i0.db = v; i1.db = v; i24.db = v; i12.db = v;
   endtask

   task automatic set_idx(input logic [7:0] v);
      i0.idx = v; i1.idx = v; i24.idx = v; i12.idx = v;
   endtask

   task automatic set_ctl(input logic ld_opl, input logic ld_pc, input logic inc_pc, input logic hold);
      i0.ld_opl  = ld_opl; i1.ld_opl  = ld_opl; i24.ld_opl  = ld_opl; i12.ld_opl  = ld_opl;
      i0.ld_pc   = ld_pc;  i1.ld_pc   = ld_pc;  i24.ld_pc   = ld_pc;  i12.ld_pc   = ld_pc;
      i0.inc_pc  = inc_pc; i1.inc_pc  = inc_pc; i24.inc_pc  = inc_pc; i12.inc_pc  = inc_pc;
      i0.hold    = hold;   i1.hold    = hold;   i24.hold    = hold;   i12.hold    = hold;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      set_op(5'b00_00_0);
      set_db(8'h00);
      set_idx(8'h00);
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);

      // ---- reset values across builds
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ab16", i0.AB, 32'hFFFC);
      chk("rst_pc16", i0.PC, 32'h0000);
      chk("rst_busy", i1.busy, 32'h0);
      chk("rst_ab24", i24.AB, 32'h00FFFC);
      chk("rst_ab12", i12.AB, 32'hFFC);

      // ---- leave reset, 0+1 and PC <= FFFC+1
      rst = 1'b0;
      set_op(5'b00_01_0);
      set_ctl(1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      chk("ad_zero_plus1", i0.AD, 32'h0001);
      tick();
      chk("ab_after_rel", i0.AB, 32'h0001);
      chk("pc_fffd", i0.PC, 32'hFFFD);
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);

      // ---- async reset mid-cycle
      #2 rst = 1'b1;
      #1;
      chk("async_ab", i0.AB, 32'hFFFC);
      chk("async_pc", i0.PC, 32'h0000);
      chk("async_busy", i1.busy, 32'h0);
      #1 rst = 1'b0;
      set_op(5'b10_01_0);
      #1;
      chk("ad_pc_plus1", i0.AD, 32'h0001);
      tick();
      chk("ab_pc_plus1", i0.AB, 32'h0001);
      chk("ab_pc_plus1_fx", i1.AB, 32'h0001);

      // ---- absolute indexed with page cross
      set_db(8'h34);
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      set_op(5'b01_00_0);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      set_db(8'h12);
      set_idx(8'hF0);
      set_op(5'b11_10_0);
      #1;
      chk("absx_ad", i0.AD, 32'h1324);
      chk("absx_pcross", i0.page_cross, 32'h1);
      chk("absx_ad_fx", i1.AD, 32'h1224);
      chk("absx_pcross_fx", i1.page_cross, 32'h1);
      tick();
      chk("absx_ab", i0.AB, 32'h1324);
      chk("absx_busy", i0.busy, 32'h0);
      chk("absx_ab_fx1", i1.AB, 32'h1224);
      chk("absx_busy_fx1", i1.busy, 32'h1);
      set_op(5'b00_00_0);                  // ignored by the fix-up cycle
      #1;
      chk("fix_ad", i1.AD, 32'h1324);
      chk("fix_pcross", i1.page_cross, 32'h0);
      tick();
      chk("fix_ab", i1.AB, 32'h1324);
      chk("fix_busy", i1.busy, 32'h0);
      chk("op0_ab", i0.AB, 32'h0000);

      // ---- fix-up held by hold, PC captures the unfixed AB
      set_op(5'b11_10_0);
      tick();
      chk("hfix_ab1", i1.AB, 32'h1224);
      set_op(5'b00_00_0);
      set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      chk("hold_ab", i1.AB, 32'h1224);
      chk("hold_busy", i1.busy, 32'h1);
      set_ctl(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("hfix_ab2", i1.AB, 32'h1324);
      chk("hfix_busy", i1.busy, 32'h0);
      chk("pc_unfixed", i1.PC, 32'h1225);
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);

      // ---- page wrap
      set_db(8'hFF);
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      set_op(5'b01_00_0);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      set_db(8'h00);
      set_idx(8'h02);
      set_op(5'b11_10_1);
      #1;
      chk("wrap_ad", i0.AD, 32'h0001);
      chk("wrap_pcross", i0.page_cross, 32'h0);
      chk("wrap_pcross_fx", i1.page_cross, 32'h0);
      tick();
      chk("wrap_ab_fx", i1.AB, 32'h0001);
      chk("wrap_busy_fx", i1.busy, 32'h0);

      // ---- decrement across a page, idx unknown
      set_db(8'h00);
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      set_op(5'b01_00_0);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      set_db(8'h03);
      set_op(5'b11_00_0);
      tick();
      chk("dec_setup", i0.AB, 32'h0300);
      set_idx(8'hxx);
      set_op(5'b01_11_0);
      #1;
      chk("dec_ad", i0.AD, 32'h02FF);
      chk("dec_pcross", i0.page_cross, 32'h1);
      chk("dec_ad_fx", i1.AD, 32'h03FF);
      tick();
      chk("dec_ab_fx1", i1.AB, 32'h03FF);
      chk("dec_busy_fx1", i1.busy, 32'h1);
      set_idx(8'h00);
      set_op(5'b01_00_0);
      tick();
      chk("dec_ab_fx2", i1.AB, 32'h02FF);

      // ---- PC loads
      set_db(8'hCD);
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      set_db(8'hAB);
      set_op(5'b11_00_0);
      tick();
      chk("abcd_ab", i0.AB, 32'hABCD);
      set_op(5'b01_00_0);
      set_ctl(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("pc_abce", i0.PC, 32'hABCE);
      set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("pc_abcd", i0.PC, 32'hABCD);

      // ---- top-of-memory wrap in every build
      set_db(8'hFF);
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      set_op(5'b11_00_0);
      tick();
      chk("ffff_ab", i0.AB, 32'hFFFF);
      chk("ffff_ab24", i24.AB, 32'h00FFFF);
      chk("ffff_ab12", i12.AB, 32'hFFF);
      set_op(5'b01_01_0);
      set_ctl(1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      chk("top_ad", i0.AD, 32'h0000);
      chk("top_pcross", i0.page_cross, 32'h1);
      chk("top_ad_fx", i1.AD, 32'hFF00);
      tick();
      chk("top_pc", i0.PC, 32'h0000);
      chk("top_ab", i0.AB, 32'h0000);
      chk("top_ab24", i24.AB, 32'h010000);
      chk("top_ab12", i12.AB, 32'h000);
      chk("top_ab_fx1", i1.AB, 32'hFF00);
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      set_op(5'b01_00_0);
      tick();
      chk("top_ab_fx2", i1.AB, 32'h0000);

      // ---- reset during a fix-up cycle
      set_op(5'b01_11_0);
      tick();
      chk("rfix_busy1", i1.busy, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("rfix_busy", i1.busy, 32'h0);
      chk("rfix_ab", i1.AB, 32'hFFFC);
      #1 rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ab_gen.md
Name: ab_gen

Overview:
- Parametrised full-width address generator. Successor to the split ADL/ABH adder blocks.
- Computes the next address bus value from a selectable base plus offset, with carry/borrow across the page boundary.
- Holds the registered address bus AB, the program counter PC and an operand-low latch.
- Optionally inserts a 6502-style page-cross fix-up cycle. Sits between the microcode sequencer and the external bus.

Parameters:
AW, 16, address width (AW > PW)
PW, 8, page (low part) width; equals data bus width
FIXUP, 0, 1 = defer page-boundary carry/borrow by one cycle (NMOS mode); 0 = single-cycle full add
RESET_AB, 16'hFFFC, AB value on reset (truncated/extended to AW)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
op  in  5  [4:3] base select, [2:1] offset select, [0] page-wrap
db  in  PW  data bus
idx  in  PW  index register value, zero-extended
ld_opl  in  1  capture db into operand latch OPL
ld_pc  in  1  load PC
inc_pc  in  1  add 1 when loading PC
hold  in  1  freeze AB, state and OPL (RDY low)
AD  out  AW  unregistered next address
AB  out  AW  registered address bus
PC  out  AW  program counter
page_cross  out  1  combinational: carry/borrow out of low PW bits in current computation
busy  out  1  registered: fix-up cycle in progress

Behaviour:
- Reset (async, rst=1): AB=RESET_AB, PC=0, OPL=0, state=IDLE, busy=0. AD, page_cross follow combinationally.
- Base by op[4:3]:
  - 00: 0
  - 01: AB
  - 10: PC
  - 11: {db zero-extended to AW-PW bits, OPL}
- Offset by op[2:1]:
  - 00: +0
  - 01: +1
  - 10: +idx
  - 11: -1 (all ones, AW wide)
- Low sum: base[PW-1:0] + offset low, PW+1 bits. Carry/borrow = bit PW; page_cross = that bit (borrow for -1 = no carry out).
- op[0]=1 (wrap): high part = base high unchanged; page_cross forced 0; no fix-up.
- op[0]=0, FIXUP=0: AD = full AW-bit sum mod 2^AW, one cycle.
- op[0]=0, FIXUP=1, state IDLE:
  - AD = {base high, low sum}.
  - If page_cross: next state FIXUP; carry direction latched (+1 for add, -1 for the -1 offset).
- State FIXUP:
  - op ignored; AD = AB with high part incremented or decremented per the latched direction (mod 2^(AW-PW)); page_cross=0.
  - Next state IDLE. busy=1 throughout this cycle.
- AB <= AD each clk unless hold=1. hold=1 also freezes state and OPL; FIXUP persists across hold.
- OPL <= db when ld_opl & !hold.
- PC:
  - ld_pc=1 → PC <= AB + inc_pc, mod 2^AW, using the pre-edge AB.
  - Not affected by hold. ld_pc during FIXUP captures the unfixed AB.
- Wrap-around: FFFF+1 → 0000 (FIXUP=0). In FIXUP mode, high FF+carry → 00.
- Reset asserted mid-FIXUP: immediate return to IDLE, AB=RESET_AB.
- All arithmetic unsigned, truncating. No X propagation from idx when offset is not idx.

Test Plan:
- Reset: assert rst async mid-cycle → AB=FFFC, PC=0000, busy=0 before next edge. Release; op=5'b10_01_0 with PC=0 → AB=0001.
- Absolute indexed, FIXUP=0: db=34, ld_opl; then db=12, idx=F0, op=11_10_0 → AB=1324, page_cross=1 seen on AD cycle, busy stays 0.
- Same with FIXUP=1:
  - cycle 1: AB=1224, busy→1.
  - cycle 2: AB=1324, busy→0, op ignored.
  - Repeat with hold=1 during fix-up: AB stays 1224 until hold drops.
- Page wrap: OPL=FF, db=00, idx=02, op=11_10_1 → AB=0001, page_cross=0, no fix-up. Decrement AB=0300 with op=01_11_0, FIXUP=1 → 03FF then 02FF.
- PC load: AB=ABCD, ld_pc=1, inc_pc=1 → PC=ABCE. AB=FFFF, inc_pc=1 → PC=0000. ld_pc during FIXUP cycle → PC = unfixed AB (+inc_pc).
- Parametrised build AW=24, PW=8: AB=00FFFF, op=01_01_0 → 010000. AW=12 reset value truncates to FFC.
